// File: rtl/interp_pkg.sv
// Definitions shared by the upsampling delay line and the 7-tap interpolation filter.
package interp_pkg;

    localparam int NTAPS = 7;

    function automatic int tap_width(input int data_width);
        return data_width + 2;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        STUFF = 1'b1
    } state_e;

endpackage

// File: rtl/registrador_deslocamento.sv
// DEPTH-deep shift register of WIDTH-bit words; word 0 (LSBs of taps) is the newest entry.
module registrador_deslocamento
    import interp_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = NTAPS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en,
    input  logic [WIDTH-1:0]         din,
    output logic [DEPTH*WIDTH-1:0]   taps
);

    logic [DEPTH*WIDTH-1:0] taps_d;
    logic [DEPTH*WIDTH-1:0] taps_q;

    always_comb begin
        taps_d = taps_q;
        if (shift_en) begin
            taps_d = {taps_q[(DEPTH-1)*WIDTH-1:0], din};
        end
    end

    // NOTE: the window is reset because every word is a visible output; a plain
    // data memory behind a valid flag would normally be left without reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_q <= '0;
        end else begin
            // NOTE: non-blocking so every word samples the pre-edge window together.
            taps_q <= taps_d;
        end
    end

    assign taps = taps_q;

endmodule

// File: rtl/linha_atraso_up.sv
// Upsampling tap delay line: inserts UPSAMPLE-1 stuffed samples after each input.
// Optional macro LINHA_ATRASO_HOLD_EN: stuffed slots repeat the last sample (zero-order hold).
module linha_atraso_up
    import interp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int UPSAMPLE   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   in_sample,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH+1:0]   tap0,
    output logic [DATA_WIDTH+1:0]   tap1,
    output logic [DATA_WIDTH+1:0]   tap2,
    output logic [DATA_WIDTH+1:0]   tap3,
    output logic [DATA_WIDTH+1:0]   tap4,
    output logic [DATA_WIDTH+1:0]   tap5,
    output logic [DATA_WIDTH+1:0]   tap6,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int TW = tap_width(DATA_WIDTH);
    localparam int PW = 4;
    localparam logic [PW-1:0] LAST_PHASE = PW'(UPSAMPLE - 1);

    state_e           state_d, state_q;
    logic [PW-1:0]    phase_d, phase_q;
    logic             out_valid_d, out_valid_q;
    logic             free;
    logic             shift_en;
    logic [TW-1:0]    shift_val;
    logic [TW-1:0]    sample_ext;
    logic [TW-1:0]    stuff_val;
    logic [NTAPS*TW-1:0] taps;

    assign sample_ext = {{2{in_sample[DATA_WIDTH-1]}}, in_sample};
    assign free       = !out_valid_q || out_ready;
    assign in_ready   = (state_q == IDLE) && free;

`ifdef LINHA_ATRASO_HOLD_EN
    logic [TW-1:0] hold_d, hold_q;

    always_comb begin
        hold_d = hold_q;
        if (state_q == IDLE && in_valid && in_ready) begin
            hold_d = sample_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign stuff_val = hold_q;
`else
    assign stuff_val = '0;
`endif

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        shift_en    = 1'b0;
        shift_val   = '0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shift_en  = 1'b1;
                    shift_val = sample_ext;
                    if (UPSAMPLE > 1) begin
                        phase_d = {{(PW-1){1'b0}}, 1'b1};
                        state_d = STUFF;
                    end
                end
            end
            STUFF: begin
                if (free) begin
                    shift_en  = 1'b1;
                    shift_val = stuff_val;
                    if (phase_q == LAST_PHASE) begin
                        phase_d = '0;
                        state_d = IDLE;
                    end else begin
                        phase_d = phase_q + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        // A shift always presents a fresh window; a consumed window with no shift empties.
        out_valid_d = out_valid_q;
        if (shift_en) begin
            out_valid_d = 1'b1;
        end else if (free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
        end
    end

    registrador_deslocamento #(
        .WIDTH (TW),
        .DEPTH (NTAPS)
    ) u_janela (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .din      (shift_val),
        .taps     (taps)
    );

    assign tap0      = taps[0*TW +: TW];
    assign tap1      = taps[1*TW +: TW];
    assign tap2      = taps[2*TW +: TW];
    assign tap3      = taps[3*TW +: TW];
    assign tap4      = taps[4*TW +: TW];
    assign tap5      = taps[5*TW +: TW];
    assign tap6      = taps[6*TW +: TW];
    assign out_valid = out_valid_q;

endmodule

// File: doc/linha_atraso_up.md
# linha_atraso_up

Upsampling tap delay line that feeds the 7-tap interpolation filter stage. It accepts one signed sample per handshake and sign-extends it to the filter's DATA_WIDTH+2 input width. It inserts UPSAMPLE−1 zero samples after each input, shifting every sample (real or stuffed) through a 7-deep register window. After each shift it presents the window as tap0..tap6 with a valid/ready handshake. The filter consumes the window combinationally: tap0 maps to in0 (newest sample) and tap6 maps to in6 (oldest).

## Interface
- DATA_WIDTH, 8: input sample width; taps are DATA_WIDTH+2 bits.
- UPSAMPLE, 2: interpolation factor L, legal range 1..16.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_sample  input  DATA_WIDTH  signed input sample.
- in_valid  input  1  in_sample is valid.
- in_ready  output  1  block accepts in_sample this cycle.
- tap0..tap6  output  DATA_WIDTH+2 each  signed window; tap0 is the newest sample.
- out_valid  output  1  window holds an unconsumed update.
- out_ready  input  1  downstream consumes the window this cycle.

## Operation
- Reset values: tap0..tap6 = 0, out_valid = 0, state = IDLE, phase counter = 0. in_ready is therefore 1 immediately after reset.
- free = !out_valid || out_ready.
- Shift event: tapk ← tap(k−1) for k = 1..6, tap0 ← new value, out_valid ← 1.
- If free and no shift occurs, out_valid ← 0.
- in_ready = (state == IDLE) && free. This signal is combinational and does not depend on in_valid.
- IDLE, when in_valid && in_ready:
  - Shift in sign-extended in_sample.
  - If UPSAMPLE > 1: phase ← 1, go to STUFF.
  - If UPSAMPLE = 1: stay in IDLE.
- STUFF, when free:
  - Shift in 0 and increment phase.
  - When the shift just made was stuffed slot UPSAMPLE−1, clear phase to 0 and return to IDLE.
- STUFF, when not free: hold all state.
- in_valid is ignored in STUFF because in_ready = 0.
- Arithmetic: sign extension only (replicate bit DATA_WIDTH−1 into the two MSBs); no scaling. The 2-bit headroom and the gain compensation for L belong to the filter.
- out_ready asserted together with a shift: the new window replaces the old one and out_valid stays 1 with no bubble.
- Reset asserted mid-STUFF: the pending stuffed slots are abandoned and all registers clear asynchronously.

## Timing
- Latency: the window reflects an accepted sample on the first rising edge after acceptance.
- Throughput: at most one input per UPSAMPLE cycles and one window update per cycle.
- Taps and out_valid are registered outputs; in_ready is the only combinational output.
- Backpressure: while out_valid && !out_ready, taps, phase and state are frozen.

## Configuration
- LINHA_ATRASO_HOLD_EN defined: stuffed slots shift in the last accepted sample (zero-order hold) instead of 0. This requires one extra DATA_WIDTH+2 holding register, cleared to 0 by reset.
- LINHA_ATRASO_HOLD_EN undefined: zero-stuffing as described above.

## Structure
- Shared package interp_pkg contains:
  - NTAPS = 7
  - Function tap_width(DATA_WIDTH) = DATA_WIDTH+2
  - Two-state enum IDLE/STUFF
- interp_pkg is shared with the filter stage.
- One natural sub-module: registrador_deslocamento, a parameterized NTAPS-deep signed shift register with shift enable and async active-low reset.
- FSM, phase counter and handshake logic stay in the top level.

## Test plan
All scenarios use DATA_WIDTH = 8 and UPSAMPLE = 2 unless stated.
- Reset: rst_n low mid-run → all taps 0, out_valid 0, in_ready 1, with no clock edge required.
- Single sample: in_sample = 5 accepted with out_ready held 1:
  - Next edge: tap0 = 5, out_valid = 1, in_ready = 0.
  - Following edge: tap0 = 0, tap1 = 5, in_ready = 1.
- Sign extension: in_sample = 8'h80 → tap0 = 10'h380 (−128); in_sample = 8'h7F → tap0 = 10'h07F.
- Backpressure: out_ready = 0 for 3 cycles after the first shift → taps stable, out_valid = 1, no zero shifted in. The stuffed zero enters on the first edge with out_ready = 1.
- Stream of samples 1..7 with out_ready = 1, after 14 shifts:
  - Without the macro: tap0..tap6 = 0,7,0,6,0,5,0.
  - With LINHA_ATRASO_HOLD_EN: tap0..tap6 = 7,7,6,6,5,5,4.
- UPSAMPLE = 1, continuous in_valid: one sample accepted per cycle, in_ready constantly 1, no zeros inserted.
- Reset during STUFF: taps clear to 0, state returns to IDLE, and the next sample enters with phase = 1.
